// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch for the 16-bit core. It owns the PC, drives the
//            IF/ID register, holds one stalled word in a skid buffer, drains a
//            flushed request, and stops on HLT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE  = 4'hF,
    parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_BLOCKED = 2'd1,
        S_HALT    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_ifid_valid;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc;
    logic        r_skid_valid;
    logic [15:0] r_skid_instr;
    logic [15:0] r_skid_pc;
    logic        r_halt_pending;
    logic        r_imem_req;
    logic [15:0] r_imem_addr;
    logic        r_halted;

    state_t      w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic        w_ifid_valid_nxt;
    logic [15:0] w_ifid_instr_nxt;
    logic [15:0] w_ifid_pc_nxt;
    logic        w_skid_valid_nxt;
    logic [15:0] w_skid_instr_nxt;
    logic [15:0] w_skid_pc_nxt;
    logic        w_halt_pending_nxt;
    logic [15:0] w_addr_nxt;
    logic        w_is_hlt;
    logic        w_hold_ifid;

    assign w_is_hlt    = (imem_data[15:12] == HALT_OPCODE);
    // A stalled decode only blocks capture when IF/ID actually holds something.
    assign w_hold_ifid = stall && r_ifid_valid;

    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_ifid_valid_nxt   = r_ifid_valid;
        w_ifid_instr_nxt   = r_ifid_instr;
        w_ifid_pc_nxt      = r_ifid_pc;
        w_skid_valid_nxt   = r_skid_valid;
        w_skid_instr_nxt   = r_skid_instr;
        w_skid_pc_nxt      = r_skid_pc;
        w_halt_pending_nxt = r_halt_pending;

        if (redirect) begin
            w_ifid_valid_nxt   = 1'b0;
            w_skid_valid_nxt   = 1'b0;
            w_halt_pending_nxt = 1'b0;
            w_pc_nxt           = redirect_pc & 16'hFFFE;
            case (r_state)
                S_FETCH, S_DRAIN: w_state_nxt = imem_rdy ? S_FETCH : S_DRAIN;
                default:          w_state_nxt = S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_rdy) begin
                        if (!w_hold_ifid) begin
                            w_ifid_instr_nxt = imem_data;
                            w_ifid_pc_nxt    = r_pc;
                            w_ifid_valid_nxt = 1'b1;
                        end else begin
                            w_skid_instr_nxt = imem_data;
                            w_skid_pc_nxt    = r_pc;
                            w_skid_valid_nxt = 1'b1;
                        end
                        if (w_is_hlt) begin
                            w_halt_pending_nxt = 1'b1;
                            w_state_nxt        = w_hold_ifid ? S_BLOCKED : S_HALT;
                        end else begin
                            w_pc_nxt    = r_pc + 16'd2;
                            w_state_nxt = w_hold_ifid ? S_BLOCKED : S_FETCH;
                        end
                    end else if (!stall) begin
                        w_ifid_valid_nxt = 1'b0;
                    end
                end
                S_BLOCKED: begin
                    if (!stall) begin
                        w_ifid_instr_nxt = r_skid_instr;
                        w_ifid_pc_nxt    = r_skid_pc;
                        w_ifid_valid_nxt = 1'b1;
                        w_skid_valid_nxt = 1'b0;
                        w_state_nxt      = r_halt_pending ? S_HALT : S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!stall) begin
                        w_ifid_valid_nxt = 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (imem_rdy) begin
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end

        // While draining, the address must stay on the abandoned request.
        w_addr_nxt = (w_state_nxt == S_DRAIN) ? r_imem_addr : w_pc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_PC;
            r_ifid_valid   <= 1'b0;
            r_ifid_instr   <= BUBBLE_INSTR;
            r_ifid_pc      <= 16'h0000;
            r_skid_valid   <= 1'b0;
            r_skid_instr   <= 16'h0000;
            r_skid_pc      <= 16'h0000;
            r_halt_pending <= 1'b0;
            r_imem_req     <= 1'b1;
            r_imem_addr    <= RESET_PC;
            r_halted       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_ifid_valid   <= w_ifid_valid_nxt;
            r_ifid_instr   <= w_ifid_valid_nxt ? w_ifid_instr_nxt : BUBBLE_INSTR;
            r_ifid_pc      <= w_ifid_pc_nxt;
            r_skid_valid   <= w_skid_valid_nxt;
            r_skid_instr   <= w_skid_instr_nxt;
            r_skid_pc      <= w_skid_pc_nxt;
            r_halt_pending <= w_halt_pending_nxt;
            r_imem_req     <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN);
            r_imem_addr    <= w_addr_nxt;
            r_halted       <= (w_state_nxt == S_HALT);
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign if_id_instr = r_ifid_instr;
    assign if_id_pc    = r_ifid_pc;
    assign if_id_valid = r_ifid_valid;
    assign halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Randomized bench for fetch_stage against a word-level fetch model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [15:0] RESET_PC     = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE  = 4'hF;
    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    fetch_stage #(
        .RESET_PC    (RESET_PC),
        .HALT_OPCODE (HALT_OPCODE),
        .BUBBLE_INSTR(BUBBLE_INSTR)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: the fetch stream seen as words moving pc -> skid -> IF/ID.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } word_t;

    word_t       skid_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_daddr;
    bit          m_drain;
    bit          m_halt;
    bit          m_hp;
    bit          m_v;
    logic [15:0] m_instr;
    logic [15:0] m_ifpc;

    function automatic bit m_fetching();
        return !m_drain && (skid_q.size() == 0) && !m_halt;
    endfunction

    task automatic model_step();
        word_t w;
        if (rst) begin
            skid_q.delete();
            m_pc = RESET_PC; m_daddr = RESET_PC;
            m_drain = 0; m_halt = 0; m_hp = 0;
            m_v = 0; m_instr = BUBBLE_INSTR; m_ifpc = 16'h0000;
        end else if (redirect) begin
            if ((m_fetching() || m_drain) && !imem_rdy) begin
                if (!m_drain) m_daddr = m_pc;
                m_drain = 1;
            end else begin
                m_drain = 0;
            end
            skid_q.delete();
            m_halt = 0; m_hp = 0; m_v = 0; m_instr = BUBBLE_INSTR;
            m_pc = {redirect_pc[15:1], 1'b0};
        end else if (m_drain) begin
            if (imem_rdy) m_drain = 0;
        end else if (skid_q.size() != 0) begin
            if (!stall) begin
                w = skid_q.pop_front();
                m_v = 1; m_instr = w.instr; m_ifpc = w.pc;
                if (m_hp) m_halt = 1;
            end
        end else if (m_halt) begin
            if (!stall) begin m_v = 0; m_instr = BUBBLE_INSTR; end
        end else begin
            if (imem_rdy) begin
                w.instr = imem_data; w.pc = m_pc;
                if (stall && m_v) skid_q.push_back(w);
                else begin m_v = 1; m_instr = w.instr; m_ifpc = w.pc; end
                if (imem_data[15:12] == HALT_OPCODE) begin
                    m_hp = 1;
                    if (skid_q.size() == 0) m_halt = 1;
                end else begin
                    m_pc = 16'((32'(m_pc) + 2) % 65536);
                end
            end else if (!stall) begin
                m_v = 0; m_instr = BUBBLE_INSTR;
            end
        end
    endtask

    task automatic check_outputs();
        bit req;
        req = m_fetching() || m_drain;
        chk("imem_req", 16'(imem_req), 16'(req));
        if (req) chk("imem_addr", imem_addr, m_drain ? m_daddr : m_pc);
        chk("if_id_valid", 16'(if_id_valid), 16'(m_v));
        chk("if_id_instr", if_id_instr, m_v ? m_instr : BUBBLE_INSTR);
        if (m_v) chk("if_id_pc", if_id_pc, m_ifpc);
        chk("halted", 16'(halted), 16'(m_halt));
    endtask

    task automatic cyc(input logic s, input logic r, input logic [15:0] rp,
                       input logic rd, input logic [15:0] d);
        stall = s; redirect = r; redirect_pc = rp; imem_rdy = rd; imem_data = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        logic [15:0] d;
        int p_rdy, p_stall;
        rst = 1'b1;
        cyc(0, 0, 16'h0, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'h1234);
        rst = 1'b0;

        // zero-wait streaming, then a 3-cycle stall while data keeps arriving
        repeat (3) cyc(0, 0, 16'h0, 1, 16'h1234);
        repeat (3) cyc(1, 0, 16'h0, 1, 16'h1234);
        repeat (2) cyc(0, 0, 16'h0, 1, 16'h1234);

        // redirect during a slow request: drained, then fetch at 0x0040
        cyc(0, 0, 16'h0, 0, 16'h0);
        cyc(0, 1, 16'h0040, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'hAAAA);
        cyc(0, 0, 16'h0, 1, 16'h1111);

        // HLT at 0x0010, then a redirect out of halt to 0x0020
        cyc(0, 1, 16'h0010, 1, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'hF000);
        repeat (2) cyc(0, 0, 16'h0, 1, 16'h1234);
        cyc(0, 1, 16'h0020, 0, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'h2222);

        // PC wrap and odd redirect target
        cyc(0, 1, 16'hFFFE, 1, 16'h0);
        repeat (2) cyc(0, 0, 16'h0, 1, 16'h1000);
        cyc(0, 1, 16'h0031, 1, 16'h0);
        cyc(0, 0, 16'h0, 1, 16'h1000);

        // redirect together with stall while a word is in the skid
        cyc(1, 0, 16'h0, 1, 16'h1234);
        cyc(1, 1, 16'h0080, 1, 16'h5555);
        repeat (2) cyc(0, 0, 16'h0, 1, 16'h1234);

        for (int i = 0; i < 3000; i++) begin
            p_rdy   = (i % 600 < 200) ? 100 : 55;
            p_stall = (i % 500 < 250) ? 15 : 45;
            rst = ($urandom_range(0, 299) == 0);
            d = 16'($urandom);
            if (d[15:12] == HALT_OPCODE && $urandom_range(0, 5) != 0) d[15:12] = 4'h1;
            cyc($urandom_range(0, 99) < p_stall,
                $urandom_range(0, 99) < 8,
                16'($urandom),
                $urandom_range(0, 99) < p_rdy,
                d);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
